// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) mod P conversion using one binary
// extended-Euclid inverter and one MSB-first interleaved modular multiplier.
module jacobian_to_affine #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_output,
  output logic [WIDTH-1:0] y_output,
  output logic             inf_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, INV, MUL_Z2, MUL_Z3, MUL_X, MUL_Y, DONE} state_t;

  state_t          r_state;
  logic            r_inReady, r_outValid, r_inf;
  logic [WIDTH-1:0] r_x, r_y, r_u, r_v, r_a, r_b, r_zi, r_t2, r_t3;
  logic [WIDTH-1:0] r_acc, r_mulA, r_mulB, r_xOut, r_yOut;
  logic [CW-1:0]   r_cnt;

  logic [WIDTH-1:0] w_xRed, w_yRed, w_zRed;
  logic [WIDTH-1:0] w_aHalf, w_bHalf, w_aSub, w_bSub;
  logic [WIDTH:0]   w_dbl, w_sum;
  logic [WIDTH-1:0] w_dblRed, w_mulRes;
  logic             w_mulLast;

  always_comb begin
    w_xRed = (x_in >= P) ? x_in - P : x_in;
    w_yRed = (y_in >= P) ? y_in - P : y_in;
    w_zRed = (z_in >= P) ? z_in - P : z_in;
    // (a+P)>>1 for odd a and odd P, written without a WIDTH+1-bit carry
    w_aHalf = r_a[0] ? (r_a >> 1) + (P >> 1) + ONE : (r_a >> 1);
    w_bHalf = r_b[0] ? (r_b >> 1) + (P >> 1) + ONE : (r_b >> 1);
    w_aSub  = (r_a >= r_b) ? r_a - r_b : r_a - r_b + P;
    w_bSub  = (r_b >= r_a) ? r_b - r_a : r_b - r_a + P;
    w_dbl    = {r_acc, 1'b0};
    w_dblRed = (w_dbl >= {1'b0, P}) ? w_dbl[WIDTH-1:0] - P : w_dbl[WIDTH-1:0];
    w_sum    = {1'b0, w_dblRed} + (r_mulB[WIDTH-1] ? {1'b0, r_mulA} : '0);
    w_mulRes = (w_sum >= {1'b0, P}) ? w_sum[WIDTH-1:0] - P : w_sum[WIDTH-1:0];
    w_mulLast = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_inf      <= 1'b0;
      r_x <= '0; r_y <= '0; r_u <= '0; r_v <= '0; r_a <= '0; r_b <= '0;
      r_zi <= '0; r_t2 <= '0; r_t3 <= '0; r_acc <= '0; r_mulA <= '0; r_mulB <= '0;
      r_xOut <= '0; r_yOut <= '0; r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_inReady <= 1'b0;
          r_x <= w_xRed;
          r_y <= w_yRed;
          if (w_zRed == '0) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
            r_inf      <= 1'b1;
            r_xOut     <= '0;
            r_yOut     <= '0;
          end else begin
            r_state <= INV;
            r_u <= w_zRed; r_v <= P; r_a <= ONE; r_b <= '0;
          end
        end
        INV: begin
          if (r_u == ONE) begin
            r_zi <= r_a; r_mulA <= r_a; r_mulB <= r_a; r_acc <= '0; r_cnt <= '0;
            r_state <= MUL_Z2;
          end else if (r_v == ONE) begin
            r_zi <= r_b; r_mulA <= r_b; r_mulB <= r_b; r_acc <= '0; r_cnt <= '0;
            r_state <= MUL_Z2;
          end else if (!r_u[0]) begin
            r_u <= r_u >> 1; r_a <= w_aHalf;
          end else if (!r_v[0]) begin
            r_v <= r_v >> 1; r_b <= w_bHalf;
          end else if (r_u >= r_v) begin
            r_u <= r_u - r_v; r_a <= w_aSub;
          end else begin
            r_v <= r_v - r_u; r_b <= w_bSub;
          end
        end
        MUL_Z2, MUL_Z3, MUL_X, MUL_Y: begin
          r_acc  <= w_mulRes;
          r_mulB <= r_mulB << 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_mulLast) begin
            // Each product finishes by loading the operands of the next one
            r_acc <= '0;
            r_cnt <= '0;
            case (r_state)
              MUL_Z2: begin
                r_t2 <= w_mulRes; r_mulA <= w_mulRes; r_mulB <= r_zi; r_state <= MUL_Z3;
              end
              MUL_Z3: begin
                r_t3 <= w_mulRes; r_mulA <= r_t2; r_mulB <= r_x; r_state <= MUL_X;
              end
              MUL_X: begin
                r_x <= w_mulRes; r_mulA <= r_t3; r_mulB <= r_y; r_state <= MUL_Y;
              end
              default: begin
                r_xOut     <= r_x;
                r_yOut     <= w_mulRes;
                r_inf      <= 1'b0;
                r_outValid <= 1'b1;
                r_state    <= DONE;
              end
            endcase
          end
        end
        DONE: if (out_ready) begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign x_output  = r_xOut;
  assign y_output  = r_yOut;
  assign inf_out   = r_inf;

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed bench for jacobian_to_affine: secp256k1 generator vectors, infinity,
// unreduced inputs, output back-pressure and mid-conversion reset.
module tb_jacobian_to_affine;

  localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam int TIMEOUT = 3000;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, inf_out;
  logic [255:0] x_in, y_in, z_in, x_output, y_output;
  int checks = 0;
  int errors = 0;

  jacobian_to_affine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_output(x_output), .y_output(y_output), .inf_out(inf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] modAdd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] mulSmall(input logic [255:0] a, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = modAdd(r, a);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drives one capture; returns at the falling edge just after the capturing rising edge
  task automatic applyStimulus(input string tag, input logic [255:0] x, input logic [255:0] y,
                               input logic [255:0] z);
    @(negedge clk);
    checkBit({tag, "_inReadyIdle"}, in_ready, 1'b1);
    x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x_in = '1; y_in = '1; z_in = '1;
    checkBit({tag, "_inReadyDrop"}, in_ready, 1'b0);
  endtask

  task automatic waitOutValid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkBit({tag, "_outValidTimeout"}, out_valid, 1'b1);
  endtask

  task automatic runAndCheck(input string tag, input logic [255:0] x, input logic [255:0] y,
                             input logic [255:0] z, input logic [255:0] ex, input logic [255:0] ey,
                             input logic einf);
    applyStimulus(tag, x, y, z);
    waitOutValid(tag);
    checkOutput({tag, "_x"}, x_output, ex);
    checkOutput({tag, "_y"}, y_output, ey);
    checkBit({tag, "_inf"}, inf_out, einf);
    @(negedge clk);
    checkBit({tag, "_outValidClr"}, out_valid, 1'b0);
    checkBit({tag, "_inReadyBack"}, in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    checkBit("rst_outValid", out_valid, 1'b0);
    checkOutput("rst_x", x_output, '0);
    checkOutput("rst_y", y_output, '0);
    checkBit("rst_inf", inf_out, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkBit("rst_inReady", in_ready, 1'b1);

    $display("[TB] Z=1 generator");
    runAndCheck("t1", GX, GY, 256'd1, GX, GY, 1'b0);

    $display("[TB] Z=2 scaled generator");
    runAndCheck("t2", mulSmall(GX, 4), mulSmall(GY, 8), 256'd2, GX, GY, 1'b0);

    $display("[TB] Z=3 scaled generator");
    runAndCheck("t2b", mulSmall(GX, 9), mulSmall(GY, 27), 256'd3, GX, GY, 1'b0);

    $display("[TB] unreduced X/Y inputs");
    runAndCheck("unred", P + 256'd5, P + 256'd7, 256'd1, 256'd5, 256'd7, 1'b0);

    $display("[TB] Z=0 infinity");
    applyStimulus("t3", 256'h1234, 256'h5678, 256'd0);
    checkBit("t3_outValidLat", out_valid, 1'b1);
    checkOutput("t3_x", x_output, '0);
    checkOutput("t3_y", y_output, '0);
    checkBit("t3_inf", inf_out, 1'b1);
    @(negedge clk);
    checkBit("t3_outValidClr", out_valid, 1'b0);
    checkBit("t3_inReadyBack", in_ready, 1'b1);

    $display("[TB] Z=P-1 and Z=P");
    runAndCheck("t4", GX, GY, P - 256'd1, GX, P - GY, 1'b0);
    runAndCheck("t4p", GX, GY, P, '0, '0, 1'b1);

    $display("[TB] output back-pressure");
    out_ready = 1'b0;
    applyStimulus("t5", mulSmall(GX, 4), mulSmall(GY, 8), 256'd2);
    waitOutValid("t5");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkBit("t5_holdValid", out_valid, 1'b1);
      checkBit("t5_holdInReady", in_ready, 1'b0);
      checkOutput("t5_holdX", x_output, GX);
      checkOutput("t5_holdY", y_output, GY);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkBit("t5_outValidClr", out_valid, 1'b0);
    checkBit("t5_inReadyBack", in_ready, 1'b1);
    checkOutput("t5_keepX", x_output, GX);

    $display("[TB] reset during MUL_X");
    applyStimulus("t6", GX, GY, 256'd1);
    repeat (600) @(negedge clk);
    checkBit("t6_notDoneYet", out_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_rstX", x_output, '0);
    checkOutput("t6_rstY", y_output, '0);
    checkBit("t6_rstValid", out_valid, 1'b0);
    checkBit("t6_rstInf", inf_out, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkBit("t6_inReady", in_ready, 1'b1);
    checkBit("t6_noOutput", out_valid, 1'b0);
    runAndCheck("t6b", GX, GY, 256'd1, GX, GY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
